// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline.
// Covers the address and instruction widths, the opcode field, the fetch FSM states and the bubble encoding.
package mips16_pkg;

   localparam int ADDR_W = 8;
   localparam int INST_W = 16;

   localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

   // Opcode field is inst[15:12]
   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam logic [3:0] HALT_OP = 4'hF;

   localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

   typedef enum logic [1:0] {
      WARM   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   function automatic logic is_halt_op(input logic [INST_W-1:0] inst);
      return inst[OP_MSB:OP_LSB] == HALT_OP;
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage.
// Priority is redirect target, then hold, then pc+1; the increment wraps at ADDR_W bits.
module fetch_next_pc
   import mips16_pkg::*;
(
   input  logic [ADDR_W-1:0] pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              hold,
   output logic [ADDR_W-1:0] pc_inc,
   output logic [ADDR_W-1:0] next_pc
);

   assign pc_inc = pc + 1'b1;

   always_comb begin
      next_pc = pc_inc;
      if (redirect)
         next_pc = redirect_pc;
      else if (hold)
         next_pc = pc;
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches from combinational instruction memory, and fills the IF/ID register.
// Define FETCH_PERF_EN to add the perf_fetched / perf_bubbles saturating event counters.
module fetch_stage
   import mips16_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_inst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [INST_W-1:0] if_id_inst,
   output logic [ADDR_W-1:0] if_id_pc1,
   output logic              if_id_valid,
   output logic              halted,
   output fetch_state_e      state
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]       perf_fetched,
   output logic [15:0]       perf_bubbles
`endif
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] next_pc;
   logic              redirect_eff;
   logic              is_halt;
   logic              fetch_evt;
   logic              bubble_evt;
   logic              pc_hold;

   // Stall freezes pc and IF/ID unless a redirect is present; redirect always wins
   // (except in WARM, where memory is still loading and nothing is fetched).
   assign redirect_eff = redirect && (state != WARM);
   assign is_halt      = is_halt_op(imem_inst);
   assign fetch_evt    = (state == RUN) && !redirect && !stall;
   assign bubble_evt   = (state == WARM) || redirect_eff || ((state == HALTED) && !stall);
   assign pc_hold      = stall || (state != RUN) || is_halt;
   assign imem_addr    = pc;

   fetch_next_pc u_next_pc (
      .pc          (pc),
      .redirect    (redirect_eff),
      .redirect_pc (redirect_pc),
      .hold        (pc_hold),
      .pc_inc      (pc_inc),
      .next_pc     (next_pc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= RESET_PC;
         if_id_inst  <= NOP_INST;
         if_id_pc1   <= '0;
         if_id_valid <= 1'b0;
         halted      <= 1'b0;
         state       <= WARM;
      end else begin
         pc <= next_pc;
         if (bubble_evt) begin
            if_id_inst  <= NOP_INST;
            if_id_pc1   <= '0;
            if_id_valid <= 1'b0;
         end else if (fetch_evt) begin
            if_id_inst  <= imem_inst;
            if_id_pc1   <= pc_inc;
            if_id_valid <= 1'b1;
         end
         case (state)
            WARM: state <= RUN;
            RUN: begin
               if (fetch_evt && is_halt) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end
            end
            HALTED: begin
               if (redirect) begin
                  state  <= RUN;
                  halted <= 1'b0;
               end
            end
            default: state <= WARM;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetched <= '0;
         perf_bubbles <= '0;
      end else begin
         if (fetch_evt && perf_fetched != 16'hFFFF)
            perf_fetched <= perf_fetched + 16'd1;
         if (bubble_evt && perf_bubbles != 16'hFFFF)
            perf_bubbles <= perf_bubbles + 16'd1;
      end
   end
`endif

endmodule
